// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with parametrised width, depth and read latency,
// deterministic same-address arbitration and sticky collision/command error flags.
module dual_port_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_a,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              cs_b,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              coll_err,
  output logic              op_err,
  input  logic              clr_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit BYPASS = (WR_FIRST != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_a, w_rd_a, w_ill_a;
  logic              w_wr_b, w_rd_b, w_ill_b;
  logic              w_same, w_coll;
  logic [DATA_W-1:0] w_rdval_a, w_rdval_b;

  logic              r_vld_a_p0, r_vld_b_p0;
  logic [DATA_W-1:0] r_rdata_a_p0, r_rdata_b_p0;
  logic              r_coll_err, r_op_err;

  assign w_wr_a  = cs_a & we_a & ~re_a;
  assign w_rd_a  = cs_a & re_a & ~we_a;
  assign w_ill_a = cs_a & we_a & re_a;
  assign w_wr_b  = cs_b & we_b & ~re_b;
  assign w_rd_b  = cs_b & re_b & ~we_b;
  assign w_ill_b = cs_b & we_b & re_b;

  assign w_same = (addr_a == addr_b);
  assign w_coll = w_wr_a & w_wr_b & w_same;

  // A reading port is never writing, so the only forwarding source is the other port.
  assign w_rdval_a = (BYPASS && w_wr_b && w_same) ? wdata_b : r_mem[addr_a];
  assign w_rdval_b = (BYPASS && w_wr_a && w_same) ? wdata_a : r_mem[addr_b];

  // Storage: port A wins a same-address write collision.
  always_ff @(posedge clk) begin
    if (w_wr_a)
      r_mem[addr_a] <= wdata_a;
    if (w_wr_b && !w_coll)
      r_mem[addr_b] <= wdata_b;
  end

  // ---- stage p0: array read / forward capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_a_p0   <= 1'b0;
      r_vld_b_p0   <= 1'b0;
      r_rdata_a_p0 <= '0;
      r_rdata_b_p0 <= '0;
    end else begin
      r_vld_a_p0 <= w_rd_a;
      r_vld_b_p0 <= w_rd_b;
      if (w_rd_a)
        r_rdata_a_p0 <= w_rdval_a;
      if (w_rd_b)
        r_rdata_b_p0 <= w_rdval_b;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_vld_a_p1, r_vld_b_p1;
      logic [DATA_W-1:0] r_rdata_a_p1, r_rdata_b_p1;

      // ---- stage p1: optional output register ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_a_p1   <= 1'b0;
          r_vld_b_p1   <= 1'b0;
          r_rdata_a_p1 <= '0;
          r_rdata_b_p1 <= '0;
        end else begin
          r_vld_a_p1 <= r_vld_a_p0;
          r_vld_b_p1 <= r_vld_b_p0;
          if (r_vld_a_p0)
            r_rdata_a_p1 <= r_rdata_a_p0;
          if (r_vld_b_p0)
            r_rdata_b_p1 <= r_rdata_b_p0;
        end
      end

      assign rdata_a  = r_rdata_a_p1;
      assign rvalid_a = r_vld_a_p1;
      assign rdata_b  = r_rdata_b_p1;
      assign rvalid_b = r_vld_b_p1;
    end else begin : g_lat1
      assign rdata_a  = r_rdata_a_p0;
      assign rvalid_a = r_vld_a_p0;
      assign rdata_b  = r_rdata_b_p0;
      assign rvalid_b = r_vld_b_p0;
    end
  endgenerate

  // A new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_err <= 1'b0;
      r_op_err   <= 1'b0;
    end else begin
      r_coll_err <= (r_coll_err & ~clr_err) | w_coll;
      r_op_err   <= (r_op_err & ~clr_err) | w_ill_a | w_ill_b;
    end
  end

  assign coll_err = r_coll_err;
  assign op_err   = r_op_err;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: two instances (RD_LAT=1/WR_FIRST=0 and RD_LAT=2/WR_FIRST=1)
// share one random + directed stimulus stream and are compared against a behavioural model.
module tb_dual_port_ram_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs_a, we_a, re_a, cs_b, we_b, re_b, clr_err;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;

  logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic       rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
  logic       coll0, op0, coll1, op1;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .WR_FIRST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cs_a(cs_a), .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .cs_b(cs_b), .we_b(we_b), .re_b(re_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .coll_err(coll0), .op_err(op0), .clr_err(clr_err)
  );

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2), .WR_FIRST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cs_a(cs_a), .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .cs_b(cs_b), .we_b(we_b), .re_b(re_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .coll_err(coll1), .op_err(op1), .clr_err(clr_err)
  );

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] e_rd_a0, e_rd_b0, e_rd_a1, e_rd_b1;
  logic       e_rv_a0, e_rv_b0, e_rv_a1, e_rv_b1;
  logic       e_coll, e_op;
  logic       p_rv_a, p_rv_b;
  logic [7:0] p_d_a, p_d_b;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // op: 0 idle (we/re random, must be ignored), 1 write, 2 read, 3 illegal
  task automatic cmd_a(input int op, input logic [7:0] ad, input logic [7:0] dt);
    cs_a = (op != 0); addr_a = ad; wdata_a = dt;
    we_a = (op == 0) ? 1'($urandom) : (op == 1 || op == 3);
    re_a = (op == 0) ? 1'($urandom) : (op == 2 || op == 3);
  endtask

  task automatic cmd_b(input int op, input logic [7:0] ad, input logic [7:0] dt);
    cs_b = (op != 0); addr_b = ad; wdata_b = dt;
    we_b = (op == 0) ? 1'($urandom) : (op == 1 || op == 3);
    re_b = (op == 0) ? 1'($urandom) : (op == 2 || op == 3);
  endtask

  task automatic idle();
    cmd_a(0, 8'h00, 8'h00);
    cmd_b(0, 8'h00, 8'h00);
    clr_err = 1'b0;
  endtask

  task automatic check_all();
    check_val("rv_a0", rvalid_a0, e_rv_a0);
    check_val("rd_a0", rdata_a0, e_rd_a0);
    check_val("rv_b0", rvalid_b0, e_rv_b0);
    check_val("rd_b0", rdata_b0, e_rd_b0);
    check_val("coll0", coll0, e_coll);
    check_val("op0", op0, e_op);
    check_val("rv_a1", rvalid_a1, e_rv_a1);
    check_val("rd_a1", rdata_a1, e_rd_a1);
    check_val("rv_b1", rvalid_b1, e_rv_b1);
    check_val("rd_b1", rdata_b1, e_rd_b1);
    check_val("coll1", coll1, e_coll);
    check_val("op1", op1, e_op);
  endtask

  // One clock with the currently driven inputs; model advanced, outputs checked 1 unit later.
  task automatic step();
    logic       rd_a, wr_a, ill_a, rd_b, wr_b, ill_b, same;
    logic [7:0] old_a, old_b, new_a, new_b;
    rd_a  = cs_a && re_a && !we_a;
    wr_a  = cs_a && we_a && !re_a;
    ill_a = cs_a && we_a && re_a;
    rd_b  = cs_b && re_b && !we_b;
    wr_b  = cs_b && we_b && !re_b;
    ill_b = cs_b && we_b && re_b;
    same  = (addr_a == addr_b);
    old_a = m_mem[addr_a];
    old_b = m_mem[addr_b];
    new_a = (wr_b && same) ? wdata_b : old_a;
    new_b = (wr_a && same) ? wdata_a : old_b;
    @(posedge clk);
    if (wr_a) m_mem[addr_a] = wdata_a;
    if (wr_b && !(wr_a && same)) m_mem[addr_b] = wdata_b;
    e_coll = (e_coll && !clr_err) || (wr_a && wr_b && same);
    e_op   = (e_op && !clr_err) || ill_a || ill_b;
    e_rv_a0 = rd_a;
    e_rv_b0 = rd_b;
    if (rd_a) e_rd_a0 = old_a;
    if (rd_b) e_rd_b0 = old_b;
    e_rv_a1 = p_rv_a;
    e_rv_b1 = p_rv_b;
    if (p_rv_a) e_rd_a1 = p_d_a;
    if (p_rv_b) e_rd_b1 = p_d_b;
    p_rv_a = rd_a; p_d_a = new_a;
    p_rv_b = rd_b; p_d_b = new_b;
    #1;
    check_all();
  endtask

  task automatic model_reset();
    e_rd_a0 = '0; e_rd_b0 = '0; e_rd_a1 = '0; e_rd_b1 = '0;
    e_rv_a0 = 0;  e_rv_b0 = 0;  e_rv_a1 = 0;  e_rv_b1 = 0;
    e_coll = 0; e_op = 0;
    p_rv_a = 0; p_rv_b = 0; p_d_a = '0; p_d_b = '0;
  endtask

  // Called 1 unit after a rising edge: asserts reset mid-cycle, checks outputs immediately.
  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op_a, op_b;
    logic [7:0] ad_a, ad_b;
    idle();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < 128; i++) begin
      cmd_a(1, 8'(2 * i), 8'($urandom));
      cmd_b(1, 8'(2 * i + 1), 8'($urandom));
      clr_err = 1'b0;
      step();
    end

    // Random traffic, addresses clustered to provoke same-address cases.
    for (int i = 0; i < 600; i++) begin
      op_a = $urandom_range(0, 9);
      op_b = $urandom_range(0, 9);
      op_a = (op_a < 2) ? 0 : (op_a < 5) ? 1 : (op_a < 9) ? 2 : 3;
      op_b = (op_b < 2) ? 0 : (op_b < 5) ? 1 : (op_b < 9) ? 2 : 3;
      ad_a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h50 + $urandom_range(0, 3));
      ad_b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h50 + $urandom_range(0, 3));
      cmd_a(op_a, ad_a, 8'($urandom));
      cmd_b(op_b, ad_b, 8'($urandom));
      clr_err = ($urandom_range(0, 15) == 0);
      step();
    end

    idle(); clr_err = 1'b1; step();

    // A writes 0x10, B reads it back one cycle later.
    idle(); cmd_a(1, 8'h10, 8'hA5); step();
    idle(); cmd_b(2, 8'h10, 8'h00); step();
    check_val("tp1_rd_b", rdata_b0, 8'hA5);
    check_val("tp1_rv_b", rvalid_b0, 1'b1);
    idle(); step();
    check_val("tp1_rv_b_end", rvalid_b0, 1'b0);
    check_val("tp1_lat2_rd_b", rdata_b1, 8'hA5);

    // Back-to-back reads through the two-cycle pipeline.
    idle(); cmd_a(1, 8'h11, 8'h5A); step();
    idle(); cmd_a(1, 8'h12, 8'hC3); step();
    idle(); cmd_b(2, 8'h10, 8'h00); step();
    check_val("tp2_rv0", rvalid_b1, 1'b0);
    idle(); cmd_b(2, 8'h11, 8'h00); step();
    check_val("tp2_rv1", rvalid_b1, 1'b1);
    check_val("tp2_d1", rdata_b1, 8'hA5);
    idle(); cmd_b(2, 8'h12, 8'h00); step();
    check_val("tp2_rv2", rvalid_b1, 1'b1);
    check_val("tp2_d2", rdata_b1, 8'h5A);
    idle(); step();
    check_val("tp2_rv3", rvalid_b1, 1'b1);
    check_val("tp2_d3", rdata_b1, 8'hC3);
    idle(); step();
    check_val("tp2_rv_end", rvalid_b1, 1'b0);
    check_val("tp2_hold", rdata_b1, 8'hC3);

    // Write/write collision: A wins, coll_err sticky until cleared.
    idle(); cmd_a(1, 8'h20, 8'h11); cmd_b(1, 8'h20, 8'h22); step();
    check_val("tp3_coll", coll0, 1'b1);
    idle(); step();
    check_val("tp3_sticky", coll1, 1'b1);
    idle(); cmd_a(2, 8'h20, 8'h00); step();
    check_val("tp3_rd", rdata_a0, 8'h11);
    idle(); clr_err = 1'b1; step();
    check_val("tp3_clr", coll0, 1'b0);

    // Write A plus read B on the same address: old vs new data.
    idle(); cmd_a(1, 8'h30, 8'h00); step();
    idle(); cmd_a(1, 8'h30, 8'h3C); cmd_b(2, 8'h30, 8'h00); step();
    check_val("tp4_old", rdata_b0, 8'h00);
    check_val("tp4_nocoll", coll0, 1'b0);
    idle(); step();
    check_val("tp4_new", rdata_b1, 8'h3C);

    // Illegal command: no write, no read, op_err set; clear in same cycle loses.
    idle(); cmd_a(1, 8'h40, 8'h77); step();
    idle(); cmd_a(3, 8'h40, 8'hEE); clr_err = 1'b1; step();
    check_val("tp5_rv", rvalid_a0, 1'b0);
    check_val("tp5_op", op0, 1'b1);
    idle(); step();
    check_val("tp5_rv_lat2", rvalid_a1, 1'b0);
    idle(); cmd_a(2, 8'h40, 8'h00); step();
    check_val("tp5_mem", rdata_a0, 8'h77);

    // Reset with a read in flight in the two-cycle instance.
    idle(); cmd_a(2, 8'h10, 8'h00); step();
    do_reset();
    check_val("tp6_rd0", rdata_a0, 8'h00);
    check_val("tp6_op", op0, 1'b0);
    idle(); step();
    check_val("tp6_rv1", rvalid_a1, 1'b0);
    idle(); step();
    idle(); cmd_a(2, 8'h10, 8'h00); step();
    check_val("tp6_keep", rdata_a0, 8'hA5);
    idle(); step();
    check_val("tp6_keep_lat2", rdata_a1, 8'hA5);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
- True dual-port synchronous RAM with one storage array shared by two independent ports, A and B.
- Width, depth and read latency are parametrised.
- Supersedes the fixed 8x256 two-bank RAM and its inout data buses. This block has separate write-data and read-data buses, a read-valid strobe, deterministic collision arbitration and sticky error flags.
- Sits between bus masters and local storage in the datapath.

Parameters:
- DATA_W, 8, data word width in bits (1..64).
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles, 1 or 2; 2 adds an output register stage.
- WR_FIRST, 0, same-cycle read/write to the same address: 0 = read returns old data, 1 = read returns new data.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_a  in  1  port A chip select.
- we_a  in  1  port A write enable.
- re_a  in  1  port A read enable.
- addr_a  in  ADDR_W  port A address.
- wdata_a  in  DATA_W  port A write data.
- rdata_a  out  DATA_W  port A read data.
- rvalid_a  out  1  port A read data valid.
- cs_b, we_b, re_b, addr_b, wdata_b, rdata_b, rvalid_b: same directions, widths and meanings for port B.
- coll_err  out  1  sticky: both ports wrote the same address in one cycle.
- op_err  out  1  sticky: some port asserted we and re together with cs.
- clr_err  in  1  synchronous clear of coll_err and op_err.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata_a, rdata_b go to 0; rvalid_a, rvalid_b go to 0.
  - coll_err, op_err go to 0; the pipeline stages clear.
  - Array contents are not reset.
  - Deassertion is sampled synchronously; the first operation is accepted on the first rising edge with rst_n high.
- Port command decode, per port per cycle:
  - cs=0: idle; we and re are ignored.
  - cs=1, we=1, re=0: write wdata to mem[addr] at the clock edge.
  - cs=1, re=1, we=0: read mem[addr].
  - cs=1, we=1, re=1: illegal. No write, no read, rvalid stays 0 for that slot, op_err sets.
- Read latency:
  - RD_LAT=1: a read accepted at edge N drives rdata and rvalid=1 after edge N, valid during cycle N+1.
  - RD_LAT=2: same, one cycle later.
  - rvalid is a one-cycle pulse per accepted read. Back-to-back reads give continuous rvalid.
  - rdata holds its last value when rvalid=0.
- Write latency: a write at edge N is visible to any read accepted at edge N+1 or later, on either port.
- Same-address collisions (addresses equal, both cs=1, legal commands):
  - Write A plus write B: port A data is stored, port B write is dropped, coll_err sets.
  - Write on one port plus read on the other: the read returns old data if WR_FIRST=0, wdata if WR_FIRST=1. No error.
  - Read plus read: both return the same data.
- Different addresses: both ports operate fully independently in the same cycle.
- Addresses: full range 0..2**ADDR_W-1; no wrap or bounds logic is needed.
- Error flags:
  - Both flags are sticky until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the flag ends set.
- Reset mid-operation: in-flight reads are discarded with no rvalid. A write on the same edge as reset assertion is undefined and not checked.
- No combinational path from any input to any output.

Test Plan:
- Reset, then with DATA_W=8, ADDR_W=8, RD_LAT=1: A writes 8'hA5 to 0x10, then B reads 0x10 -> rdata_b=8'hA5 with rvalid_b=1 exactly one cycle after the read edge.
- RD_LAT=2: B reads 0x10, 0x11, 0x12 back-to-back -> rvalid_b high for 3 consecutive cycles starting two cycles after the first read, data in order.
- Same edge: A writes 8'h11 to 0x20 and B writes 8'h22 to 0x20 -> a later read of 0x20 returns 8'h11; coll_err=1 until clr_err pulses, then 0.
- Same edge: A writes 8'h3C to 0x30 (old value 8'h00) and B reads 0x30 -> rdata_b=8'h00 when WR_FIRST=0, 8'h3C when WR_FIRST=1.
- cs_a=1, we_a=1, re_a=1 at 0x40 -> mem[0x40] unchanged, rvalid_a stays 0, op_err=1.
- Issue a read on A, then drop rst_n low mid-cycle before the data returns -> outputs go to 0 immediately, no rvalid_a after release. Array data written before reset is still readable afterwards.
